// File: rtl/mem_burst_ctrl.sv
// Burst controller between a simple requester and a single-port synchronous RAM.
// Issues 1..8 consecutive-word write or read beats per request, with registered read return.
module mem_burst_ctrl #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              Read,
  output logic              Write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWr      = 3'd1,
    StRd      = 3'd2,
    StRdDrain = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                rvalid_q;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0]   din_hold_q, din_hold_d;

  // State register.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= Read;
      addr_hold_q <= addr_hold_d;
      din_hold_q  <= din_hold_d;
    end
  end

  // Next-state and burst bookkeeping.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cur_addr_d = addr;
          cnt_d      = len;
          state_d    = we ? StWr : StRd;
        end
      end
      StWr, StRd: begin
        // Address wraps naturally at 2^ADDR_W.
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        cnt_d      = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = (state_q == StWr) ? StDone : StRdDrain;
        end
      end
      StRdDrain: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    Read    = 1'b0;
    Write   = 1'b0;
    wready  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    address = addr_hold_q;
    DataIn  = din_hold_q;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StWr: begin
        Write   = 1'b1;
        wready  = 1'b1;
        address = cur_addr_q;
        DataIn  = wdata;
      end
      StRd: begin
        Read    = 1'b1;
        address = cur_addr_q;
      end
      StRdDrain: ;
      StDone:    done = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // RAM address and write data hold their last driven values outside beats.
  always_comb begin
    addr_hold_d = addr_hold_q;
    din_hold_d  = din_hold_q;
    if (Read || Write) begin
      addr_hold_d = cur_addr_q;
    end
    if (Write) begin
      din_hold_d = wdata;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rvalid_q ? DataOut : '0;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: RAM model plus a word-level expected memory,
// directed scenarios and randomized bursts checked cycle by cycle.
module tb_mem_burst_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 512;

  logic          Clock = 1'b0;
  logic          clear = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [2:0]    len = '0;
  logic [DW-1:0] wdata = '0;
  logic          wready, rvalid, busy, done, Read, Write;
  logic [DW-1:0] rdata, DataIn, DataOut;
  logic [AW-1:0] address;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] wbuf    [8];
  logic [DW-1:0] last_din;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  mem_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock   (Clock),
    .clear   (clear),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .len     (len),
    .wdata   (wdata),
    .wready  (wready),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy),
    .done    (done),
    .Read    (Read),
    .Write   (Write),
    .address (address),
    .DataIn  (DataIn),
    .DataOut (DataOut)
  );

  // Synchronous RAM with registered read data; pl_* is a backdoor preload port.
  always @(posedge Clock) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (Write === 1'b1) ram[address] <= DataIn;
    if (Read === 1'b1) DataOut <= ram[address];
  end

  always @(negedge Clock) begin
    if (clear === 1'b0) begin
      checks++;
      if (Read === 1'b1 && Write === 1'b1) begin
        errors++;
        $display("FAIL rw_exclusive: Read=%b Write=%b, required not both 1", Read, Write);
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    exp_mem[a] = d;
    @(posedge Clock); #2;
    pl_en = 1'b0;
  endtask

  // One complete burst, checked every cycle from acceptance to the following IDLE cycle.
  task automatic run_burst(input bit w, input logic [AW-1:0] a, input int n, input string tag);
    int            guard, rv_cnt, done_cnt, last_c;
    logic [4:0]    exp_ctl;
    logic          exp_rv;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din, exp_rd;
    guard = 0;
    while (busy !== 1'b0 && guard < 50) begin
      @(posedge Clock); #2;
      guard++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_wait: busy=%b, required 0", tag, busy);
    end
    req = 1'b1; we = w; addr = a; len = 3'(n - 1); wdata = wbuf[0];
    rv_cnt = 0; done_cnt = 0;
    last_c = w ? n + 2 : n + 3;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge Clock); #1;
      if (c == 1) begin
        // Scramble request fields: they must only matter at acceptance.
        req = 1'b0; we = ~w; addr = AW'($urandom); len = 3'($urandom);
      end
      wdata = (w && c <= n) ? wbuf[c-1] : DW'($urandom);
      #1;
      exp_addr = (c <= n) ? AW'(int'(a) + c - 1) : AW'(int'(a) + n - 1);
      if (w) begin
        exp_din = (c <= n) ? wbuf[c-1] : wbuf[n-1];
        exp_ctl = (c <= n) ? 5'b01110 : (c == n + 1) ? 5'b00011 : 5'b00000;
        exp_rv  = 1'b0;
      end else begin
        exp_din = last_din;
        exp_ctl = (c <= n) ? 5'b10010 : (c == n + 1) ? 5'b00010 :
                  (c == n + 2) ? 5'b00011 : 5'b00000;
        exp_rv  = (c >= 2 && c <= n + 1);
      end
      checks++;
      if ({Read, Write, wready, busy, done} !== exp_ctl) begin
        errors++;
        $display("FAIL %s_ctl c=%0d: {Read,Write,wready,busy,done}=%b, required %b",
                 tag, c, {Read, Write, wready, busy, done}, exp_ctl);
      end
      checks++;
      if (address !== exp_addr) begin
        errors++;
        $display("FAIL %s_address c=%0d: got %h, required %h", tag, c, address, exp_addr);
      end
      checks++;
      if (DataIn !== exp_din) begin
        errors++;
        $display("FAIL %s_datain c=%0d: got %h, required %h", tag, c, DataIn, exp_din);
      end
      checks++;
      if (rvalid !== exp_rv) begin
        errors++;
        $display("FAIL %s_rvalid c=%0d: got %b, required %b", tag, c, rvalid, exp_rv);
      end
      if (exp_rv) begin
        exp_rd = exp_mem[AW'(int'(a) + c - 2)];
        checks++;
        if (rdata !== exp_rd) begin
          errors++;
          $display("FAIL %s_rdata c=%0d: got %h, required %h", tag, c, rdata, exp_rd);
        end
      end
      if (rvalid === 1'b1) rv_cnt++;
      if (done === 1'b1) done_cnt++;
      if (w && c <= n) exp_mem[exp_addr] = wbuf[c-1];
    end
    if (w) last_din = wbuf[n-1];
    checks++;
    if (rv_cnt != (w ? 0 : n)) begin
      errors++;
      $display("FAIL %s_rvalid_count: got %0d, required %0d", tag, rv_cnt, w ? 0 : n);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, required 1", tag, done_cnt);
    end
  endtask

  task automatic test_reset();
    #1 clear = 1'b1;
    #1;
    checks++;
    if ({Read, Write, wready, rvalid, busy, done} !== 6'b0 || address !== '0 || DataIn !== '0) begin
      errors++;
      $display("FAIL reset_async: ctl=%b address=%h DataIn=%h, required all 0",
               {Read, Write, wready, rvalid, busy, done}, address, DataIn);
    end
    for (int i = 0; i < DEPTH; i++) preload(AW'(i), DW'($urandom));
    checks++;
    if ({Read, Write, wready, rvalid, busy, done} !== 6'b0 || address !== '0 || DataIn !== '0) begin
      errors++;
      $display("FAIL reset_held: ctl=%b address=%h DataIn=%h, required all 0",
               {Read, Write, wready, rvalid, busy, done}, address, DataIn);
    end
    last_din = '0;
    clear = 1'b0;
  endtask

  task automatic test_single_write();
    wbuf[0] = 32'hDEADBEEF;
    run_burst(1'b1, 9'h010, 1, "single_wr");
    run_burst(1'b0, 9'h010, 1, "single_rd");
  endtask

  task automatic test_read_burst();
    for (int i = 0; i < 4; i++) preload(AW'(9'h100 + i), DW'(i + 1));
    run_burst(1'b0, 9'h100, 4, "read4");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) wbuf[i] = DW'($urandom);
    run_burst(1'b1, 9'h1FE, 4, "wrap_wr");
    run_burst(1'b0, 9'h1FE, 4, "wrap_rd");
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = DW'($urandom);
      run_burst(1'($urandom), AW'($urandom), $urandom_range(1, 8), "rand");
    end
  endtask

  // req held high: bursts repeat with exactly one IDLE cycle between them.
  task automatic test_back_to_back();
    int            n, rv_cnt, done_cnt;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_rd;
    n = $urandom_range(1, 8);
    a = AW'($urandom);
    req = 1'b1; we = 1'b0; addr = a; len = 3'(n - 1);
    for (int k = 0; k < 3; k++) begin
      rv_cnt = 0; done_cnt = 0;
      for (int j = 0; j < n + 3; j++) begin
        @(posedge Clock); #2;
        if (k == 2 && j == n + 2) req = 1'b0;
        checks++;
        if (busy !== (j < n + 2)) begin
          errors++;
          $display("FAIL b2b_busy k=%0d j=%0d: got %b, required %b", k, j, busy, j < n + 2);
        end
        if (rvalid === 1'b1) begin
          rv_cnt++;
          exp_rd = exp_mem[AW'(int'(a) + j - 1)];
          checks++;
          if (rdata !== exp_rd) begin
            errors++;
            $display("FAIL b2b_rdata k=%0d j=%0d: got %h, required %h", k, j, rdata, exp_rd);
          end
        end
        if (done === 1'b1) done_cnt++;
      end
      checks++;
      if (rv_cnt != n || done_cnt != 1) begin
        errors++;
        $display("FAIL b2b_counts k=%0d: rvalid=%0d done=%0d, required %0d and 1",
                 k, rv_cnt, done_cnt, n);
      end
    end
    @(posedge Clock); #2;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_req_dropped: busy=%b, required 0", busy);
    end
  endtask

  // Clear during beat 3 of an 8-beat write: only beats 1-2 may reach the RAM.
  task automatic test_clear_mid();
    logic [AW-1:0] a;
    a = AW'($urandom);
    for (int i = 0; i < 8; i++) wbuf[i] = DW'($urandom);
    req = 1'b1; we = 1'b1; addr = a; len = 3'd7; wdata = wbuf[0];
    for (int c = 1; c <= 3; c++) begin
      @(posedge Clock); #1;
      req = 1'b0;
      wdata = wbuf[c-1];
      #1;
      checks++;
      if (Write !== 1'b1 || address !== AW'(int'(a) + c - 1)) begin
        errors++;
        $display("FAIL clr_beat c=%0d: Write=%b address=%h, required 1 and %h",
                 c, Write, address, AW'(int'(a) + c - 1));
      end
    end
    clear = 1'b1;
    #1;
    checks++;
    if ({Read, Write, wready, rvalid, busy, done} !== 6'b0 || address !== '0 || DataIn !== '0) begin
      errors++;
      $display("FAIL clr_async: ctl=%b address=%h DataIn=%h, required all 0",
               {Read, Write, wready, rvalid, busy, done}, address, DataIn);
    end
    repeat (2) begin
      @(posedge Clock); #2;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL clr_no_done: done=%b busy=%b, required 0 and 0", done, busy);
      end
    end
    clear = 1'b0;
    exp_mem[a]              = wbuf[0];
    exp_mem[AW'(int'(a)+1)] = wbuf[1];
    last_din = '0;
    run_burst(1'b0, a, 8, "clr_readback");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_wrap();
    test_back_to_back();
    test_clear_mid();
    test_random();
    test_back_to_back();
    repeat (2) @(posedge Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
